// File: rtl/sfifo_ctrl.sv
// sfifo_ctrl: single-clock FIFO controller wrapped around a dual-port FIFO memory.
// Owns the read/write pointers, the occupancy count and the status flags, and
// re-times returning read data with a valid strobe matching the memory latency.
// Optional feature macro: SFIFO_ALMOST_FLAGS_EN builds the afull/aempty registers;
// without it both outputs are tied low and the thresholds are ignored.
module sfifo_ctrl #(
  parameter int p_nbit_d        = 8,
  parameter int p_nbit_a        = 4,
  parameter int p_output_reg_en = 1,
  parameter int p_afull_th      = 12,
  parameter int p_aempty_th     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr,
  input  logic [p_nbit_d-1:0] wdata,
  input  logic                rd,
  input  logic                err_clr,
  output logic [p_nbit_d-1:0] dout,
  output logic                dout_vld,
  output logic                full,
  output logic                empty,
  output logic                afull,
  output logic                aempty,
  output logic [p_nbit_a:0]   usedw,
  output logic                overflow,
  output logic                underflow,
  output logic                mem_wr,
  output logic [p_nbit_a-1:0] mem_waddr,
  output logic [p_nbit_d-1:0] mem_wdata,
  output logic                mem_rd,
  output logic [p_nbit_a-1:0] mem_raddr,
  input  logic [p_nbit_d-1:0] mem_rdata
);

  localparam int lat = 1 + p_output_reg_en;
  localparam logic [p_nbit_a:0] depth = {1'b1, {p_nbit_a{1'b0}}};
  localparam logic [p_nbit_a:0] one   = {{p_nbit_a{1'b0}}, 1'b1};

  logic [p_nbit_a:0] wptr_reg;
  logic [p_nbit_a:0] rptr_reg;
  logic [p_nbit_a:0] usedw_reg;
  logic [p_nbit_a:0] usedw_next;
  logic              full_reg;
  logic              empty_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  logic [lat-1:0]    vld_reg;
  logic              wr_ok;
  logic              rd_ok;
  logic              unused_bits;

  // Requests are qualified by the registered flags only, so a same-cycle
  // read can never free space for a write (and vice versa). This keeps the
  // memory from ever seeing a read and a write to the same address.
  assign wr_ok = wr & ~full_reg;
  assign rd_ok = rd & ~empty_reg;

  assign mem_wr    = wr_ok;
  assign mem_wdata = wdata;
  assign mem_waddr = wptr_reg[p_nbit_a-1:0];
  assign mem_rd    = rd_ok;
  assign mem_raddr = rptr_reg[p_nbit_a-1:0];

  assign dout      = mem_rdata;
  assign dout_vld  = vld_reg[lat-1];
  assign usedw     = usedw_reg;
  assign full      = full_reg;
  assign empty     = empty_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  // Next occupancy: +1 on a lone write, -1 on a lone read, unchanged otherwise.
  always_comb begin
    usedw_next = usedw_reg;
    if (wr_ok && !rd_ok) begin
      usedw_next = usedw_reg + one;
    end else if (!wr_ok && rd_ok) begin
      usedw_next = usedw_reg - one;
    end
  end

  // Pointers, occupancy and full/empty flags, all registered from usedw_next.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      usedw_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
    end else begin
      if (wr_ok) begin
        wptr_reg <= wptr_reg + one;
      end
      if (rd_ok) begin
        rptr_reg <= rptr_reg + one;
      end
      usedw_reg <= usedw_next;
      full_reg  <= (usedw_next == depth);
      empty_reg <= (usedw_next == '0);
    end
  end

  // Sticky error flags; a new error in the clearing cycle takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr && full_reg) begin
        overflow_reg <= 1'b1;
      end else if (err_clr) begin
        overflow_reg <= 1'b0;
      end
      if (rd && empty_reg) begin
        underflow_reg <= 1'b1;
      end else if (err_clr) begin
        underflow_reg <= 1'b0;
      end
    end
  end

  // Valid delay line, as long as the memory read latency; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
    end else begin
      vld_reg[0] <= rd_ok;
      for (int i = 1; i < lat; i++) begin
        vld_reg[i] <= vld_reg[i-1];
      end
    end
  end

`ifdef SFIFO_ALMOST_FLAGS_EN
  localparam logic [p_nbit_a:0] afull_th  = (p_nbit_a+1)'(p_afull_th);
  localparam logic [p_nbit_a:0] aempty_th = (p_nbit_a+1)'(p_aempty_th);

  logic afull_reg;
  logic aempty_reg;

  // Almost-full/almost-empty flags compared against the next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
    end else begin
      afull_reg  <= (usedw_next >= afull_th);
      aempty_reg <= (usedw_next <= aempty_th);
    end
  end

  assign afull       = afull_reg;
  assign aempty      = aempty_reg;
  assign unused_bits = wptr_reg[p_nbit_a] ^ rptr_reg[p_nbit_a];
`else
  assign afull       = 1'b0;
  assign aempty      = 1'b0;
  // Pointer MSBs only matter for wrap bookkeeping; thresholds are unused here.
  assign unused_bits = wptr_reg[p_nbit_a] ^ rptr_reg[p_nbit_a] ^ (p_afull_th > p_aempty_th);
`endif

endmodule

// File: doc/sfifo_ctrl.md
Name: sfifo_ctrl

Overview:
Single-clock FIFO controller that drives the dual-port FIFO memory (afifomem) and turns it into a complete synchronous FIFO. It manages write/read pointers, occupancy count and status flags, and issues memory write/read strobes and addresses. It also re-aligns returning read data with a valid strobe that matches the memory's read latency. Used wherever the WaveGen datapath needs same-clock buffering, e.g. sample staging ahead of the waveform output.

Parameters:
p_nbit_d, 8, data width; must equal the memory's p_nbit_d
p_nbit_a, 4, address width; depth = 2**p_nbit_a
p_output_reg_en, 1, must equal the memory's p_output_reg_en; read latency L = 1 + p_output_reg_en
p_afull_th, 12, afull asserted when count >= p_afull_th
p_aempty_th, 2, aempty asserted when count <= p_aempty_th

Ports:
clk  in  1  single clock; also drives the memory wclk and rclk
rst  in  1  synchronous, active-high reset
wr  in  1  write request
wdata  in  p_nbit_d  write data
rd  in  1  read request
err_clr  in  1  clears sticky overflow/underflow
dout  out  p_nbit_d  read data; meaningful only while dout_vld=1
dout_vld  out  1  read data valid
full  out  1  FIFO full
empty  out  1  FIFO empty
afull  out  1  almost full
aempty  out  1  almost empty
usedw  out  p_nbit_a+1  occupancy, 0..2**p_nbit_a
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
mem_wr  out  1  to memory wr
mem_waddr  out  p_nbit_a  to memory waddr
mem_wdata  out  p_nbit_d  to memory wdata
mem_rd  out  1  to memory rd
mem_raddr  out  p_nbit_a  to memory raddr
mem_rdata  in  p_nbit_d  from memory rdata

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: wptr=0, rptr=0, usedw=0, empty=1, full=0, afull=0, aempty=1, overflow=0, underflow=0, dout_vld pipeline all 0. Memory contents are not cleared.
- Pointers: wptr and rptr are p_nbit_a+1 bits wide. The low p_nbit_a bits drive mem_waddr and mem_raddr. Pointers wrap naturally modulo 2**(p_nbit_a+1).
- Accepted write: wr_ok = wr & ~full.
  - mem_wr = wr_ok and mem_wdata = wdata, both combinational in the same cycle.
  - wptr increments at the clock edge.
- Accepted read: rd_ok = rd & ~empty.
  - mem_rd = rd_ok and mem_raddr = rptr[p_nbit_a-1:0], both combinational.
  - rptr increments at the clock edge.
- Flags use the registered state of the current cycle:
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle.
  - This guarantees the memory never sees a same-address read and write, so the memory's mixed-port DONT_CARE mode is safe.
- Occupancy update:
  - usedw_nxt = usedw + wr_ok - rd_ok; usedw remains unchanged when both are accepted.
  - Registered flags, all derived from usedw_nxt: full = (usedw_nxt == 2**p_nbit_a), empty = (usedw_nxt == 0), afull = (usedw_nxt >= p_afull_th), aempty = (usedw_nxt <= p_aempty_th).
  - Consequence: a word written into an empty FIFO is readable on the next cycle.
- Read latency:
  - dout_vld is a shift register of length L fed by rd_ok, so dout_vld is high exactly L cycles after an accepted read.
  - dout = mem_rdata, combinational passthrough.
  - Back-to-back reads give back-to-back dout_vld, in strict FIFO order.
- Error flags:
  - overflow sets on wr & full; underflow sets on rd & empty.
  - Both are cleared by err_clr or rst; if set and clear occur in the same cycle, set wins.
- Reset mid-operation: in-flight reads are discarded. dout_vld = 0 from the cycle after rst and stays 0 until a new accepted read has aged L cycles.
- Parameter check: p_afull_th and p_aempty_th must lie within 0..2**p_nbit_a. Out-of-range values are a configuration error; the design is not required to handle them.

Optional Feature:
SFIFO_ALMOST_FLAGS_EN
- Defined: afull and aempty registers and threshold comparators are built exactly as described in Behaviour.
- Undefined: afull is tied to 0, aempty is tied to 0, the comparator logic is removed, and p_afull_th/p_aempty_th are ignored.

Test Plan:
1. Assert rst for 2 cycles -> empty=1, full=0, usedw=0, dout_vld=0, overflow=0, underflow=0, and afull=0/aempty=1 (macro defined).
2. With p_nbit_a=4, write 0x00..0x0F on consecutive cycles -> afull rises after the 12th write, full=1 and usedw=16 after the 16th; a 17th write sets overflow=1, usedw stays 16, mem_wr=0.
3. From full, with p_output_reg_en=1, read 16 times back-to-back -> dout_vld high 2 cycles after each rd, dout=0x00..0x0F in order; empty=1 after the 16th read.
4. At usedw=5, assert wr and rd together for 40 cycles with an incrementing pattern -> usedw stays 5, pointers wrap twice, output sequence is gap-free and ordered.
5. On an empty FIFO, drive wr and rd in the same cycle -> write accepted, read rejected, underflow=1, usedw=1; the next cycle's rd returns the data; pulse err_clr -> underflow=0.
6. Issue 2 reads (L=2), assert rst on the cycle after the second -> no dout_vld pulses afterwards; usedw=0, empty=1.
